// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// Latency: MTHI/MTLO/no-op done in cycle 1; MULT/MULTU done in cycle MUL_LATENCY; DIV/DIVU done in cycle WIDTH+1.
// Backpressure: i_req_valid is accepted only when idle (o_req_ready=1); the requester holds the request while busy.
//
// Ports:
//   i_clk, i_reset          clock and synchronous active-high reset
//   i_req_valid/o_req_ready request handshake; o_busy is ~o_req_ready
//   i_op                    0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MADD,7 MSUB
//   i_a, i_b                rs / rt operands (MTHI/MTLO use i_a)
//   i_flush                 abort any in-flight op and drop a same-cycle request
//   o_done                  1-cycle pulse once HI/LO hold the new result
//   o_hi, o_lo              architectural HI/LO
// Build option: define MULDIV_MADD_EN to enable MADD/MSUB (ops 6/7); otherwise they are no-ops.

module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH + MUL_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_rem;      // one spare bit so the trial subtraction's sign is visible
  logic [WIDTH-1:0] r_quo;      // dividend shifts out the top while quotient bits shift in
  logic [WIDTH-1:0] r_div_d;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_done;
  logic             r_done_pend;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_mul_sgn;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_fit;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_accept = i_req_valid & (r_state == S_IDLE) & ~i_flush;

  // Signed divide works on magnitudes; signs are reapplied in FIX.
  assign w_a_neg = (i_op == 3'd2) & i_a[WIDTH-1];
  assign w_b_neg = (i_op == 3'd2) & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // Only MULTU is unsigned; the low 2*WIDTH bits of the extended product are exact.
  assign w_mul_sgn = (r_op != 3'd1);
  assign w_ext_a   = {{WIDTH{w_mul_sgn & r_a[WIDTH-1]}}, r_a};
  assign w_ext_b   = {{WIDTH{w_mul_sgn & r_b[WIDTH-1]}}, r_b};
  assign w_prod    = w_ext_a * w_ext_b;

`ifdef MULDIV_MADD_EN
  always_comb begin
    w_mul_res = w_prod;
    if (r_op == 3'd6)      w_mul_res = {r_hi, r_lo} + w_prod;
    else if (r_op == 3'd7) w_mul_res = {r_hi, r_lo} - w_prod;
  end
`else
  assign w_mul_res = w_prod;
`endif

  // One restoring step: shift in the next dividend bit, keep the difference if it fits.
  assign w_rem_sh = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_div_d};
  assign w_fit    = ~w_diff[WIDTH];
  assign w_q_fix  = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div_d     <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div0      <= 1'b0;
      r_done      <= 1'b0;
      r_done_pend <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      // HI/LO moves write at the accept edge and report done one cycle later.
      r_done      <= r_done_pend;
      r_done_pend <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= i_op;
            r_a  <= i_a;
            r_b  <= i_b;
            case (i_op)
              3'd0, 3'd1: begin
                r_state <= S_MUL;
                r_cnt   <= CW'(MUL_LATENCY - 1);
              end
              3'd2, 3'd3: begin
                r_state <= S_DIV;
                r_cnt   <= CW'(WIDTH - 1);
                r_rem   <= '0;
                r_quo   <= w_a_mag;
                r_div_d <= w_b_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_div0  <= (i_b == '0);
              end
              3'd4: begin
                r_hi        <= i_a;
                r_done_pend <= 1'b1;
              end
              3'd5: begin
                r_lo        <= i_a;
                r_done_pend <= 1'b1;
              end
`ifdef MULDIV_MADD_EN
              default: begin
                r_state <= S_MUL;
                r_cnt   <= CW'(MUL_LATENCY - 1);
              end
`else
              default: r_done_pend <= 1'b1;
`endif
            endcase
          end
        end
        S_MUL: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            {r_hi, r_lo} <= w_mul_res;
            r_done       <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_fit ? w_diff : w_rem_sh;
            r_quo <= {r_quo[WIDTH-2:0], w_fit};
            if (r_cnt == '0) r_state <= S_FIX;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else begin
            // Divide by zero returns all-ones quotient and the raw dividend as remainder.
            if (r_div0) begin
              r_lo <= '1;
              r_hi <= r_a;
            end else begin
              r_lo <= w_q_fix;
              r_hi <= w_r_fix;
            end
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;

endmodule
